a_wr_cross_x4_ram: RTL and testbench

//  Write-side crossbar for the 4-bank emulation RAM, paired with the 4:1 read crossbar.

---
 rtl/a_wr_cross_x4_ram_pkg.sv | 29 ++
 rtl/a_wr_cross_x4_ram_if.sv | 51 +++++
 rtl/a_wr_cross_x4_ram_bank_ptr.sv | 52 +++++
 rtl/a_wr_cross_x4_ram.sv | 131 +++++++++++++
 tb/tb_a_wr_cross_x4_ram.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/a_wr_cross_x4_ram_pkg.sv
// ---------------------------------------------------------------------------
// a_wr_cross_pkg
// Shared definitions for the 4-bank emulation RAM write crossbar (and its
// 4:1 read-side partner): bank count, bank index type, FSM state encoding
// and the bank-select priority decoder.
// ---------------------------------------------------------------------------
package a_wr_cross_pkg;

  localparam int NBANK = 4;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Priority decode of the 3-bit bank select: the highest set bit wins,
  // and all-zero selects bank 0. The read crossbar uses the same code.
  function automatic bank_idx_t decode_ctrl(input logic [2:0] ctrl);
    bank_idx_t idx;
    if (ctrl[2])      idx = 2'd3;
    else if (ctrl[1]) idx = 2'd2;
    else if (ctrl[0]) idx = 2'd1;
    else              idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/a_wr_cross_x4_ram_if.sv
// ---------------------------------------------------------------------------
// a_wr_cross_x4_ram_if
// Bus between the write-stream source and the write crossbar.
//   master : drives clr_i, ctrl_i, data_i, dv_i; observes all outputs
//   slave  : the crossbar (receives inputs, drives data/we/addr/status)
// Handshake: there is no back-pressure. Every cycle with dv_i=1 is a beat;
// the crossbar always takes it (it may drop it only when the target bank is
// full in the wrap-stop build, or when clr_i is high the same cycle).
// Signals:
//   clr_i      sync clear          ctrl_i  bank select (priority code)
//   data_i     write data          dv_i    data valid
//   data_o     registered data     we_o    per-bank write enable
//   addr_o_0..addr_o_3  per-bank write address
//   busy_o     FSM in BURST        sel_o   bank of current/last burst
//   wrap_o     per-bank sticky wrap/full flag
//   dbg_state_o FSM state for observation
// ---------------------------------------------------------------------------
interface a_wr_cross_x4_ram_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  import a_wr_cross_pkg::*;

  logic            clr_i;
  logic [2:0]      ctrl_i;
  logic [DW-1:0]   data_i;
  logic            dv_i;
  logic [DW-1:0]   data_o;
  logic [NBANK-1:0] we_o;
  logic [AW-1:0]   addr_o_0;
  logic [AW-1:0]   addr_o_1;
  logic [AW-1:0]   addr_o_2;
  logic [AW-1:0]   addr_o_3;
  logic            busy_o;
  bank_idx_t       sel_o;
  logic [NBANK-1:0] wrap_o;
  state_t          dbg_state_o;

  modport master (
    output clr_i, ctrl_i, data_i, dv_i,
    input  data_o, we_o, addr_o_0, addr_o_1, addr_o_2, addr_o_3,
    input  busy_o, sel_o, wrap_o, dbg_state_o
  );

  modport slave (
    input  clr_i, ctrl_i, data_i, dv_i,
    output data_o, we_o, addr_o_0, addr_o_1, addr_o_2, addr_o_3,
    output busy_o, sel_o, wrap_o, dbg_state_o
  );

endinterface

// File: rtl/a_wr_cross_x4_ram_bank_ptr.sv
// ---------------------------------------------------------------------------
// a_wr_bank_ptr
// Write pointer and wrap/full flag for one RAM bank.
// Configuration macro: A_WR_CROSS_WRAP_STOP_EN
//   undefined : write at DEPTH-1 wraps ptr to 0 and sets sticky wrap
//   defined   : write at DEPTH-1 sets wrap (= full) and holds ptr
// Ports:
//   clk, rst (async, active high), clr (sync clear),
//   inc (a write to this bank happens this cycle) -> ptr, wrap
// ---------------------------------------------------------------------------
module a_wr_bank_ptr #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr,
  output logic          wrap
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] r_ptr;
  logic          r_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_ptr  <= '0;
      r_wrap <= 1'b0;
    end else if (inc) begin
      if (r_ptr == LAST) begin
        r_wrap <= 1'b1;
`ifdef A_WR_CROSS_WRAP_STOP_EN
        r_ptr  <= r_ptr;
`else
        r_ptr  <= '0;
`endif
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign ptr  = r_ptr;
  assign wrap = r_wrap;

endmodule

// File: rtl/a_wr_cross_x4_ram.sv
// ---------------------------------------------------------------------------
// a_wr_cross_x4_ram
// Write-side crossbar for the 4-bank emulation RAM. Steers one data-valid
// stream into one of 4 banks, generates each bank's write address and
// tracks fill/wrap per bank.
// Configuration macro: A_WR_CROSS_WRAP_STOP_EN (see a_wr_bank_ptr); when
// defined, beats aimed at a full bank are dropped.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  a_wr_cross_x4_ram_if.slave (inputs clr/ctrl/data/dv, outputs
//        data/we/addr_0..3/busy/sel/wrap/dbg_state)
// ---------------------------------------------------------------------------
module a_wr_cross_x4_ram
  import a_wr_cross_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  a_wr_cross_x4_ram_if.slave      bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  bank_idx_t        r_sel;
  logic [DW-1:0]    r_data;
  logic [NBANK-1:0] r_we;
  logic [AW-1:0]    r_addr [NBANK];

  bank_idx_t        w_dec;
  bank_idx_t        w_bank;
  logic             w_beat;
  logic [NBANK-1:0] w_full;
  logic [NBANK-1:0] w_inc;
  logic [NBANK-1:0] w_wrap;
  logic [AW-1:0]    w_ptr [NBANK];

  assign w_dec  = decode_ctrl(bus.ctrl_i);
  // The bank is chosen only on the first beat of a burst; afterwards the
  // latched bank is used and ctrl_i is ignored.
  assign w_bank = (r_state == IDLE) ? w_dec : r_sel;
  // clr_i takes precedence over a same-cycle beat.
  assign w_beat = bus.dv_i & ~bus.clr_i;

`ifdef A_WR_CROSS_WRAP_STOP_EN
  assign w_full = w_wrap;
`else
  assign w_full = '0;
`endif

  always_comb begin
    w_inc = '0;
    if (w_beat && !w_full[w_bank]) w_inc[w_bank] = 1'b1;
  end

  for (genvar k = 0; k < NBANK; k++) begin : g_bank
    a_wr_bank_ptr #(
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_ptr (
      .clk  (clk),
      .rst  (rst),
      .clr  (bus.clr_i),
      .inc  (w_inc[k]),
      .ptr  (w_ptr[k]),
      .wrap (w_wrap[k])
    );
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: a burst lasts as long as dv_i stays high. Dropped beats
  // (full bank) still keep the burst alive.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.dv_i) w_state_nxt = BURST;
        BURST:   if (!bus.dv_i) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= '0;
    end else if (bus.clr_i) begin
      r_sel <= '0;
    end else if (r_state == IDLE && bus.dv_i) begin
      r_sel <= w_dec;
    end
  end

  // Output registers: data and addresses update only on an actual write and
  // otherwise hold, so the bank sees stable values between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= '0;
      r_data <= '0;
      for (int k = 0; k < NBANK; k++) r_addr[k] <= '0;
    end else begin
      r_we <= w_inc;
      if (|w_inc) r_data <= bus.data_i;
      for (int k = 0; k < NBANK; k++) begin
        if (w_inc[k]) r_addr[k] <= w_ptr[k];
      end
    end
  end

  assign bus.data_o      = r_data;
  assign bus.we_o        = r_we;
  assign bus.addr_o_0    = r_addr[0];
  assign bus.addr_o_1    = r_addr[1];
  assign bus.addr_o_2    = r_addr[2];
  assign bus.addr_o_3    = r_addr[3];
  assign bus.busy_o      = (r_state == BURST);
  assign bus.sel_o       = r_sel;
  assign bus.wrap_o      = w_wrap;
  assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_a_wr_cross_x4_ram.sv
// ---------------------------------------------------------------------------
// tb_a_wr_cross_x4_ram
// Self-checking bench for a_wr_cross_x4_ram (DEPTH=8 so wrap is reachable).
// A reference model steps once per driven cycle and pushes the expected
// registered outputs; they are popped and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_a_wr_cross_x4_ram;
  import a_wr_cross_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int W     = 4 + DW + 4 * AW + 2 + 1 + 4;

  logic clk;
  logic rst;

  a_wr_cross_x4_ram_if #(.DW(DW), .AW(AW)) bus ();

  a_wr_cross_x4_ram #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  logic          m_burst;
  logic [1:0]    m_sel;
  logic [AW-1:0] m_ptr  [4];
  logic [3:0]    m_wrap;
  logic [DW-1:0] m_data;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr [4];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_bank(input logic [2:0] c);
    if (c[2]) return 2'd3;
    if (c[1]) return 2'd2;
    if (c[0]) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_burst = 1'b0;
    m_sel   = '0;
    m_wrap  = '0;
    m_data  = '0;
    m_we    = '0;
    for (int k = 0; k < 4; k++) begin
      m_ptr[k]  = '0;
      m_addr[k] = '0;
    end
  endtask

  task automatic model_step(input logic c, input logic [2:0] ct, input logic [DW-1:0] d,
                            input logic v);
    logic [1:0] b;
    logic       drop;
    m_we = '0;
    if (c) begin
      m_burst = 1'b0;
      m_sel   = '0;
      m_wrap  = '0;
      for (int k = 0; k < 4; k++) m_ptr[k] = '0;
    end else if (v) begin
      b = m_burst ? m_sel : ref_bank(ct);
      m_sel   = b;
      m_burst = 1'b1;
      drop = 1'b0;
`ifdef A_WR_CROSS_WRAP_STOP_EN
      drop = m_wrap[b];
`endif
      if (!drop) begin
        m_we[b]   = 1'b1;
        m_data    = d;
        m_addr[b] = m_ptr[b];
        if (int'(m_ptr[b]) == DEPTH - 1) begin
          m_wrap[b] = 1'b1;
`ifndef A_WR_CROSS_WRAP_STOP_EN
          m_ptr[b] = '0;
`endif
        end else begin
          m_ptr[b] = m_ptr[b] + 1'b1;
        end
      end
    end else begin
      m_burst = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    return {m_we, m_data, m_addr[3], m_addr[2], m_addr[1], m_addr[0], m_sel, m_burst, m_wrap};
  endfunction

  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("wrap", 32'(bus.wrap_o), 32'(e[3:0]));
    check("busy", 32'(bus.busy_o), 32'(e[4]));
    check("sel",  32'(bus.sel_o),  32'(e[6:5]));
    check("addr0", 32'(bus.addr_o_0), 32'(e[7 +: AW]));
    check("addr1", 32'(bus.addr_o_1), 32'(e[7 + AW +: AW]));
    check("addr2", 32'(bus.addr_o_2), 32'(e[7 + 2*AW +: AW]));
    check("addr3", 32'(bus.addr_o_3), 32'(e[7 + 3*AW +: AW]));
    check("data", 32'(bus.data_o), 32'(e[7 + 4*AW +: DW]));
    check("we",   32'(bus.we_o),   32'(e[W-1 -: 4]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c, input logic [2:0] ct, input logic [DW-1:0] d, input logic v);
    bus.clr_i  = c;
    bus.ctrl_i = ct;
    bus.data_i = d;
    bus.dv_i   = v;
    model_step(c, ct, d, v);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'b000, 16'h0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},   32'(bus.we_o), 32'd0);
    check({tag, "_data"}, 32'(bus.data_o), 32'd0);
    check({tag, "_addr"}, 32'(bus.addr_o_0 | bus.addr_o_1 | bus.addr_o_2 | bus.addr_o_3), 32'd0);
    check({tag, "_sel"},  32'(bus.sel_o), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_wrap"}, 32'(bus.wrap_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.clr_i  = 1'b0;
    bus.ctrl_i = 3'b000;
    bus.data_i = '0;
    bus.dv_i   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_init");
    rst = 1'b0;

    // Reset mid-stream: outputs clear immediately, then first beat -> addr 0
    for (int i = 0; i < 3; i++) drive(1'b0, 3'b010, 16'h5000 + 16'(i), 1'b1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 3'b010, 16'h5100, 1'b1);
    check("rst_first_addr2", 32'(bus.addr_o_2), 32'd0);
    idle(2);
    bus.clr_i = 1'b1;
    drive(1'b1, 3'b000, 16'h0, 1'b0);

    // Burst of 5 to bank 2
    for (int i = 0; i < 5; i++) drive(1'b0, 3'b010, 16'hA000 + 16'(i), 1'b1);
    idle(2);

    // ctrl change mid-burst has no effect; next burst goes to bank 3
    for (int i = 0; i < 6; i++) drive(1'b0, (i < 2) ? 3'b000 : 3'b100, 16'hB000 + 16'(i), 1'b1);
    check("midburst_sel", 32'(bus.sel_o), 32'd0);
    idle(1);
    for (int i = 0; i < 2; i++) drive(1'b0, 3'b100, 16'hB100 + 16'(i), 1'b1);
    check("nextburst_sel", 32'(bus.sel_o), 32'd3);
    idle(1);

    // Priority
    drive(1'b0, 3'b111, 16'hC000, 1'b1);
    check("prio_111", 32'(bus.we_o), 32'b1000);
    idle(1);
    drive(1'b0, 3'b011, 16'hC001, 1'b1);
    check("prio_011", 32'(bus.we_o), 32'b0100);
    idle(1);

    // Wrap on bank 1 from a cleared state: DEPTH+2 beats
    drive(1'b1, 3'b000, 16'h0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 3'b001, 16'hD000 + 16'(i), 1'b1);
    check("wrap_flag", 32'(bus.wrap_o), 32'b0010);
    idle(2);

    // clr with dv the same cycle: beat dropped, following beat writes addr 0
    drive(1'b0, 3'b001, 16'hE000, 1'b1);
    drive(1'b1, 3'b001, 16'hE001, 1'b1);
    check("clr_we", 32'(bus.we_o), 32'd0);
    check("clr_wrap", 32'(bus.wrap_o), 32'd0);
    drive(1'b0, 3'b100, 16'hE002, 1'b1);
    check("clr_next_addr3", 32'(bus.addr_o_3), 32'd0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) == 0), 3'($urandom_range(0, 7)),
            16'($urandom_range(0, 65535)), ($urandom_range(0, 3) != 0));
    end
    idle(2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
